div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the exec stage; serves DIV/DIVU.
//  Holds the pipeline via o_stall until the result is ready.
//  Quotient goes to LO and remainder to HI on the exec->mem path, which feeds
//  the mem stage i_mem_lo/i_mem_hi with i_mem_whi=i_mem_wlo=1.
// PARAMETERS
//  WIDTH   32                  operand/result width in bits
//  CNT_W   $clog2(WIDTH)+1     iteration counter width; derived, do not override
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset: asynchronous, active-high
//  i_start      in   1      divide request; held high by exec until o_done is seen
//  i_signed     in   1      1 = DIV (two's complement), 0 = DIVU
//  i_cancel     in   1      pipeline flush; aborts any operation
//  i_dividend   in   WIDTH  rs operand
//  i_divisor    in   WIDTH  rt operand
//  o_stall      out  1      stall request to pipeline control
//  o_done       out  1      result valid
//  o_quotient   out  WIDTH  quotient, to LO
//  o_remainder  out  WIDTH  remainder, to HI
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal registers = 0.
//  FSM states and transitions:
//   IDLE    start=1 & cancel=0 & divisor!=0 -> ON. Latch |dividend|, |divisor|,
//           neg_q = signed & (sgn(a)^sgn(b)), neg_r = signed & sgn(a); cnt=0.
//           start=1 & cancel=0 & divisor==0 -> DIVZERO.
//   ON      One iteration per cycle: shift {rem,quo} left by 1, trial-subtract
//           the divisor, keep the difference if it is non-negative, set quo LSB.
//           cnt++; after WIDTH iterations -> END.
//   DIVZERO One cycle: quotient = all ones, remainder = raw dividend -> END.
//   END     Apply signs: quo negated if neg_q; rem negated if neg_r. Results are
//           registered: o_done=1, o_quotient/o_remainder valid and stable.
//           Stays in END while i_start=1; i_start=0 -> IDLE.
//  Latency: start sampled at cycle T.
//   Normal path: ON occupies T+1..T+WIDTH; o_done=1 from T+WIDTH+1.
//   Divide by zero: o_done=1 from T+2.
//  o_stall: combinational; = i_start & ~o_done & ~i_cancel.
//   Exec stalls from the request cycle up to, but not including, the done cycle.
//  o_done: registered; high only in END. o_quotient/o_remainder keep their
//   last value in IDLE and change only on entry to END.
//  i_start is ignored outside IDLE; no re-triggering while busy.
//  i_cancel has priority over everything:
//   - any state -> IDLE next cycle; the in-flight result is discarded.
//   - o_done does not assert; o_quotient/o_remainder are not updated.
//  Simultaneous i_start and i_cancel in IDLE: cancel wins; no operation starts.
//  Arithmetic: magnitudes are taken in WIDTH bits. -2^31/-1 (signed) therefore
//   yields quotient 0x8000_0000, remainder 0 with no trap, matching MIPS.
//  Internal remainder is WIDTH+1 bits so the trial subtraction cannot overflow.
//  Asserting rst mid-operation returns immediately to IDLE with all outputs 0.
// TESTING
//  DIVU 100/7, start at T -> stall T..T+32; done T+33; q=14, r=2.
//  DIV -7/2 -> q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1).
//   DIV 7/-2 -> q=-3, r=1.
//  DIVU 5/0 -> done at T+2; q=0xFFFF_FFFF, r=5.
//  DIV 0x8000_0000/0xFFFF_FFFF -> q=0x8000_0000, r=0.
//   DIVU 0xFFFF_FFFF/1 -> q=0xFFFF_FFFF, r=0.
//  Cancel at T+10 -> IDLE at T+11, no done, outputs keep old values;
//   a new start at T+12 gives the correct result at T+45.
//  rst pulse at T+5 mid-divide -> all outputs 0 asynchronously.
//   Hold start through done for 3 cycles -> done stays 1 for 3 cycles,
//   IDLE after start drops, no second operation.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the exec stage (DIV/DIVU).
// The quotient goes to LO and the remainder to HI. The pipeline is held through
// o_stall until the result is registered.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   i_start      divide request, held by exec until o_done is seen
//   i_signed     1 = DIV (two's complement), 0 = DIVU
//   i_cancel     pipeline flush; aborts any operation and has top priority
//   i_dividend   rs operand
//   i_divisor    rt operand
//   o_stall      combinational stall request (i_start & ~o_done & ~i_cancel)
//   o_done       registered result-valid flag, high only in S_END
//   o_quotient   quotient, to LO
//   o_remainder  remainder, to HI
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON      = 2'd1,
        S_DIVZERO = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    // Combinational datapath for one iteration plus operand magnitudes.
    // The shifted partial remainder is WIDTH+1 bits so the trial subtraction
    // cannot overflow. The kept remainder is always below the divisor and
    // therefore fits back into WIDTH bits.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
        a_abs   = (i_signed && i_dividend[WIDTH-1]) ? WIDTH'(-i_dividend) : i_dividend;
        b_abs   = (i_signed && i_divisor[WIDTH-1])  ? WIDTH'(-i_divisor)  : i_divisor;
    end

    assign o_stall = i_start & ~o_done & ~i_cancel;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else if (i_cancel) begin
            // A flush drops the in-flight result and leaves the outputs as they were.
            state  <= S_IDLE;
            cnt    <= '0;
            o_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        cnt <= '0;
                        if (i_divisor == '0) begin
                            // Keep the raw dividend; it becomes the remainder.
                            rem   <= i_dividend;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= S_DIVZERO;
                        end else begin
                            rem   <= '0;
                            quo   <= a_abs;
                            dvs   <= b_abs;
                            neg_q <= i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                            neg_r <= i_signed & i_dividend[WIDTH-1];
                            state <= S_ON;
                        end
                    end
                end
                S_ON: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // Last iteration: apply signs while registering the result.
                        o_quotient  <= neg_q ? WIDTH'(-quo_nxt) : quo_nxt;
                        o_remainder <= neg_r ? WIDTH'(-rem_nxt) : rem_nxt;
                        o_done      <= 1'b1;
                        state       <= S_END;
                    end
                end
                S_DIVZERO: begin
                    o_quotient  <= '1;
                    o_remainder <= rem;
                    o_done      <= 1'b1;
                    state       <= S_END;
                end
                S_END: begin
                    if (!i_start) begin
                        o_done <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed stimulus for div_unit. A cycle-level reference model
// computes quotient and remainder with plain integer arithmetic and tracks
// when the result is due. A compare process checks every output on each
// falling edge. Directed literals pin both the model and the DUT.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_signed;
    logic        i_cancel;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_chk = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_cancel    (i_cancel),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division with 64-bit integer arithmetic (truncates toward zero).
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Timing model: a result is due WIDTH edges after the start edge
    // (or one edge for divide by zero).
    bit          m_busy, m_done;
    int          m_left;
    logic [31:0] m_q, m_r, m_pq, m_pr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_left = 0;
            m_q = '0; m_r = '0; m_pq = '0; m_pr = '0;
        end else if (i_cancel) begin
            m_busy = 0;
            m_done = 0;
        end else if (m_done) begin
            if (!i_start) m_done = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_q    = m_pq;
                m_r    = m_pr;
            end
        end else if (i_start) begin
            m_busy = 1;
            m_left = (i_divisor == 32'd0) ? 1 : 32;
            ref_div(i_dividend, i_divisor, i_signed, m_pq, m_pr);
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (run_chk) begin
            check("cyc_done",  {31'd0, o_done}, {31'd0, m_done});
            check("cyc_stall", {31'd0, o_stall}, {31'd0, i_start & ~m_done & ~i_cancel});
            check("cyc_quo",   o_quotient, m_q);
            check("cyc_rem",   o_remainder, m_r);
        end
    end

    // Start one operation, measure the latency to o_done, check the result, and
    // hold i_start for h extra edges before dropping it (done lasts h+2 cycles).
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input int lat, input int h);
        int n;
        int dcnt;
        bit got;
        @(posedge clk); #1;
        i_dividend = a; i_divisor = b; i_signed = s; i_start = 1'b1;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (o_done) got = 1;
            else n++;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected %0d", name, n, lat);
            @(posedge clk); #1 i_start = 1'b0;
        end else begin
            check({name, "_lat"}, 32'(n), 32'(lat));
            check({name, "_q"}, o_quotient, eq);
            check({name, "_r"}, o_remainder, er);
            dcnt = 1;
            for (int k = 0; k <= h; k++) begin
                @(posedge clk); #1;
                if (k == h) i_start = 1'b0;
                @(negedge clk);
                if (o_done) dcnt++;
            end
            repeat (4) begin
                @(negedge clk);
                if (o_done) dcnt++;
            end
            check({name, "_donelen"}, 32'(dcnt), 32'(h + 2));
        end
    endtask

    initial begin
        logic [31:0] q, r;
        bit saw_done;
        rst = 1'b1; i_start = 1'b0; i_signed = 1'b0; i_cancel = 1'b0;
        i_dividend = '0; i_divisor = '0;

        // Pin the reference model with hand-computed values.
        ref_div(32'd100, 32'd7, 1'b0, q, r);
        check("model_100_7_q", q, 32'd14);
        check("model_100_7_r", r, 32'd2);
        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
        check("model_m7_2_q", q, 32'hFFFF_FFFD);
        check("model_m7_2_r", r, 32'hFFFF_FFFF);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
        check("model_min_m1_q", q, 32'h8000_0000);
        check("model_min_m1_r", r, 32'd0);
        ref_div(32'd5, 32'd0, 1'b0, q, r);
        check("model_div0_q", q, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done",  {31'd0, o_done}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_quo",   o_quotient, 32'd0);
        check("rst_rem",   o_remainder, 32'd0);
        rst = 1'b0;
        run_chk = 1;

        do_op("divu_100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33, 0);
        do_op("div_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 0);
        do_op("div_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33, 0);
        do_op("divu_5_0",    32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          2,  0);
        do_op("div_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          33, 0);
        do_op("divu_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          33, 0);
        do_op("div_3_m5",    32'd3,          32'hFFFF_FFFB,  1'b1, 32'd0,          32'd3,          33, 0);
        do_op("hold_1000",   32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,          33, 1);

        // Flush at T+10: back to idle, no done, outputs keep 100/0.
        @(posedge clk); #1;
        i_dividend = 32'd77; i_divisor = 32'd3; i_signed = 1'b0; i_start = 1'b1;
        repeat (10) @(posedge clk);
        #1 i_cancel = 1'b1;
        @(posedge clk); #1;
        i_cancel = 1'b0; i_start = 1'b0;
        @(negedge clk);
        check("cancel_done", {31'd0, o_done}, 32'd0);
        check("cancel_quo",  o_quotient, 32'd100);
        check("cancel_rem",  o_remainder, 32'd0);
        do_op("after_cancel", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 33, 0);

        // Simultaneous start and cancel in idle: nothing starts.
        @(posedge clk); #1;
        i_dividend = 32'd9; i_divisor = 32'd3; i_start = 1'b1; i_cancel = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_cancel = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) saw_done = 1;
        end
        check("start_cancel_nodone", {31'd0, saw_done}, 32'd0);
        check("start_cancel_quo", o_quotient, 32'd8);

        // Reset mid-divide clears the outputs immediately.
        @(posedge clk); #1;
        i_dividend = 32'd1234; i_divisor = 32'd5; i_signed = 1'b0; i_start = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1; i_start = 1'b0;
        #1;
        check("midrst_done", {31'd0, o_done}, 32'd0);
        check("midrst_quo",  o_quotient, 32'd0);
        check("midrst_rem",  o_remainder, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        do_op("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);

        repeat (3) @(negedge clk);
        run_chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
